// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: request sequencer in front of the 32-bit combinational ALU.
// Accepts op/operand requests, decodes the opcode into the ALU select lines,
// holds the ALU inputs for SETTLE cycles, then captures and returns the result.
// Optional feature macro: ALU_ISSUE_ACC_EN (adds a result accumulator that can
// replace operand a on request).
module alu_issue_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_use_acc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_s0,
  output logic        alu_s1,
  output logic        alu_s2,
  output logic        alu_s3,
  output logic        alu_s4,
  output logic        alu_s5,
  output logic        alu_s6,
  output logic        alu_s7,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_err,
  output logic [3:0]  out_op
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // Counter starts at SETTLE-1 so capture lands exactly SETTLE edges after accept.
  localparam logic [3:0] LP_CNT_INIT = 4'(SETTLE - 1);

  // Opcode -> {s7..s0, cin}; unused opcodes decode to all zeros.
  function automatic logic [8:0] decode_op(input logic [3:0] op);
    logic [8:0] ctl;
    ctl = 9'h000;
    case (op)
      4'd0:    ctl = {8'hC0, 1'b0};
      4'd1:    ctl = {8'h40, 1'b1};
      4'd2:    ctl = {8'h21, 1'b1};
      4'd3:    ctl = {8'hA1, 1'b0};
      4'd4:    ctl = {8'h63, 1'b0};
      4'd5:    ctl = {8'hE2, 1'b0};
      4'd6:    ctl = {8'h02, 1'b0};
      4'd7:    ctl = {8'h00, 1'b0};
      4'd8:    ctl = {8'h04, 1'b0};
      4'd9:    ctl = {8'h08, 1'b0};
      4'd10:   ctl = {8'h0C, 1'b0};
      4'd11:   ctl = {8'h82, 1'b0};
      4'd12:   ctl = {8'h80, 1'b0};
      default: ctl = 9'h000;
    endcase
    return ctl;
  endfunction

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [7:0]  r_sel;
  logic        r_cin;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic        r_out_err;
  logic [3:0]  r_out_op;

  logic        w_accept;
  logic        w_legal;
  logic        w_capture;
  logic [8:0]  w_ctl;
  logic [31:0] w_op_a;

  assign w_accept  = in_valid & r_in_ready;
  assign w_legal   = (in_op <= 4'd12);
  assign w_capture = (r_state == EXEC) && (r_cnt == 4'd0);
  assign w_ctl     = decode_op(in_op);

`ifdef ALU_ISSUE_ACC_EN
  logic [31:0] r_acc;

  assign w_op_a = in_use_acc ? r_acc : in_a;

  // Accumulator follows every legally captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 32'd0;
    end else if (w_capture) begin
      r_acc <= alu_result;
    end
  end
`else
  logic w_unused_use_acc;

  assign w_unused_use_acc = in_use_acc;
  assign w_op_a           = in_a;
`endif

  // Issue FSM: accept, hold ALU inputs for the settle window, capture, hand off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_sel        <= 8'd0;
      r_cin        <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_result <= 32'd0;
      r_out_err    <= 1'b0;
      r_out_op     <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_out_op   <= in_op;
            r_in_ready <= 1'b0;
            if (w_legal) begin
              r_alu_a <= w_op_a;
              r_alu_b <= in_b;
              r_sel   <= w_ctl[8:1];
              r_cin   <= w_ctl[0];
              r_cnt   <= LP_CNT_INIT;
              r_state <= EXEC;
            end else begin
              // Illegal opcode: report straight away, ALU drives untouched.
              r_out_result <= 32'd0;
              r_out_err    <= 1'b1;
              r_out_valid  <= 1'b1;
              r_state      <= DONE;
            end
          end
        end
        EXEC: begin
          if (r_cnt == 4'd0) begin
            r_out_result <= alu_result;
            r_out_err    <= 1'b0;
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_err    = r_out_err;
  assign out_op     = r_out_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign {alu_s7, alu_s6, alu_s5, alu_s4, alu_s3, alu_s2, alu_s1, alu_s0} = r_sel;
  assign alu_cin    = r_cin;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stand-in, transaction-level
// reference model, directed cases followed by randomized requests.
module tb_alu_issue_ctrl;
  localparam int SETTLE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_use_acc;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_s0, alu_s1, alu_s2, alu_s3, alu_s4, alu_s5, alu_s6, alu_s7;
  logic        alu_cin;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;
  logic [3:0]  out_op;

  int checks = 0;
  int errors = 0;

  // Reference state: last legal ALU drives and the accumulator.
  logic [31:0] m_a, m_b, m_acc;
  logic [8:0]  m_ctl;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_s3(alu_s3),
    .alu_s4(alu_s4), .alu_s5(alu_s5), .alu_s6(alu_s6), .alu_s7(alu_s7),
    .alu_cin(alu_cin), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_err(out_err), .out_op(out_op)
  );

  logic [7:0] w_sel;
  assign w_sel = {alu_s7, alu_s6, alu_s5, alu_s4, alu_s3, alu_s2, alu_s1, alu_s0};

  // Stand-in for the ALU: behaviour chosen by the select/cin pattern.
  function automatic logic [31:0] alu_model(input logic [31:0] a, b, input logic [7:0] s, input logic c);
    case ({s, c})
      {8'hC0, 1'b0}: return a + b;
      {8'h40, 1'b1}: return a + b + 32'd1;
      {8'h21, 1'b1}: return a - b;
      {8'hA1, 1'b0}: return a - b - 32'd1;
      {8'h63, 1'b0}: return a + 32'd1;
      {8'hE2, 1'b0}: return a - 32'd1;
      {8'h02, 1'b0}: return a;
      {8'h00, 1'b0}: return a & b;
      {8'h04, 1'b0}: return a | b;
      {8'h08, 1'b0}: return ~a;
      {8'h0C, 1'b0}: return a ^ b;
      {8'h82, 1'b0}: return a << 1;
      {8'h80, 1'b0}: return a >> 1;
      default:       return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, w_sel, alu_cin);

  // Expected result by opcode meaning.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + b + 32'd1;
      4'd2:  return a - b;
      4'd3:  return a - b - 32'd1;
      4'd4:  return a + 32'd1;
      4'd5:  return a - 32'd1;
      4'd6:  return a;
      4'd7:  return a & b;
      4'd8:  return a | b;
      4'd9:  return ~a;
      4'd10: return a ^ b;
      4'd11: return a << 1;
      4'd12: return a >> 1;
      default: return 32'd0;
    endcase
  endfunction

  // Decode table as listed for the ALU: {sel, cin}.
  function automatic logic [8:0] ref_ctl(input logic [3:0] op);
    logic [8:0] tbl [13];
    tbl = '{{8'hC0,1'b0}, {8'h40,1'b1}, {8'h21,1'b1}, {8'hA1,1'b0}, {8'h63,1'b0},
            {8'hE2,1'b0}, {8'h02,1'b0}, {8'h00,1'b0}, {8'h04,1'b0}, {8'h08,1'b0},
            {8'h0C,1'b0}, {8'h82,1'b0}, {8'h80,1'b0}};
    return (op <= 4'd12) ? tbl[op] : 9'h000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_drives();
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_ctl", {23'd0, w_sel, alu_cin}, {23'd0, m_ctl});
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_op", out_op, 0);
    check_drives();
  endtask

  // One full transaction with 'bp' cycles of backpressure once the result shows.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, b, input logic use_acc, input int bp);
    logic        legal;
    logic [31:0] ea, exp_res;
    int          n;
    legal = (op <= 4'd12);
    ea = a;
`ifdef ALU_ISSUE_ACC_EN
    if (use_acc) ea = m_acc;
`endif
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_op      = op;
    in_a       = a;
    in_b       = b;
    in_use_acc = use_acc;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_a       = $urandom;
    in_b       = $urandom;
    in_op      = 4'($urandom);
    in_use_acc = 1'($urandom);
    if (legal) begin
      m_a   = ea;
      m_b   = b;
      m_ctl = ref_ctl(op);
    end
    exp_res = legal ? ref_result(op, ea, b) : 32'd0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check_drives();
      check("in_ready_busy", in_ready, 0);
    end while (!out_valid && n < 40);
    check("latency", n, legal ? SETTLE + 1 : 1);
    check("out_result", out_result, exp_res);
    check("out_err", out_err, {31'd0, ~legal});
    check("out_op", out_op, {28'd0, op});
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      in_op    = 4'd6;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, exp_res);
      check("bp_op", out_op, {28'd0, op});
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check_drives();
    if (legal) m_acc = exp_res;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_a = 32'd0; in_b = 32'd0;
    in_use_acc = 1'b0; out_ready = 1'b0;
    m_a = 32'd0; m_b = 32'd0; m_ctl = 9'd0; m_acc = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Reset while executing: in-flight op discarded.
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd4; in_b = 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < SETTLE + 3; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
    end

    // Directed cases.
    do_op(4'd0, 32'd4, 32'd4, 1'b0, 0);
    do_op(4'd2, 32'd4, 32'd4, 1'b0, 0);
    do_op(4'd4, 32'd4, 32'd0, 1'b0, 0);
    do_op(4'd10, 32'd0, 32'd1, 1'b0, 0);
    do_op(4'd14, 32'd7, 32'd9, 1'b0, 0);
    do_op(4'd3, 32'h10, 32'h3, 1'b0, 5);
    do_op(4'd0, 32'd4, 32'd4, 1'b0, 0);
    do_op(4'd11, 32'd1, 32'd0, 1'b1, 0);
    do_op(4'd6, 32'd77, 32'd0, 1'b1, 1);
    do_op(4'd15, 32'd1, 32'd1, 1'b1, 0);
    do_op(4'd6, 32'd55, 32'd0, 1'b1, 0);

    // Randomized requests.
    for (int i = 0; i < 60; i++) begin
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom,
            1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule
